// File: rtl/clock_divider_pkg.sv
// Shared constants and types for the clock divider bank.
// The optional phase-align input is enabled with `define CLOCK_DIV_SYNC_EN.
package clock_divider_pkg;

    localparam int CNT_W_DEF        = 25;
    localparam int DEFAULT_HALF_DEF = 8333333;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] half;
        logic                 enable;
    } cfg_t;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] cnt;
        logic [CNT_W_DEF-1:0] half;
        logic                 enabled;
        logic                 pending;
        cfg_t                 pend_cfg;
    } ch_state_t;

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: half-period counter, output toggle, tick and a single
// pending-config slot applied only at period boundaries (CLOCK_DIV_SYNC_EN adds sync_i).
module clock_divider_channel
    import clock_divider_pkg::*;
#(
    parameter int DEFAULT_HALF = DEFAULT_HALF_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
`ifdef CLOCK_DIV_SYNC_EN
    input  logic sync_i,
`endif
    input  logic cfg_we_i,
    input  cfg_t cfg_i,
    output logic pending_o,
    output logic clk_o,
    output logic tick_o
);

    ch_state_t st_q, st_d;
    logic      clk_q, clk_d;
    logic      tick_q, tick_d;
    logic      term;
    logic      sync;

`ifdef CLOCK_DIV_SYNC_EN
    assign sync = sync_i;
`else
    assign sync = 1'b0;
`endif

    assign term = st_q.enabled && (st_q.cnt == st_q.half);

    always_comb begin
        st_d  = st_q;
        clk_d = clk_q;
        if (sync && st_q.enabled) begin
            st_d.cnt = '0;
            clk_d    = 1'b0;
            if (st_q.pending) begin
                st_d.half    = st_q.pend_cfg.half;
                st_d.enabled = st_q.pend_cfg.enable;
                st_d.pending = 1'b0;
            end
        end else if (st_q.enabled) begin
            if (term) begin
                st_d.cnt = '0;
                // A disable waits for a falling boundary so the last high phase is full length.
                if (st_q.pending && !st_q.pend_cfg.enable) begin
                    if (clk_q) begin
                        clk_d        = 1'b0;
                        st_d.half    = st_q.pend_cfg.half;
                        st_d.enabled = 1'b0;
                        st_d.pending = 1'b0;
                    end else begin
                        clk_d = 1'b1;
                    end
                end else begin
                    clk_d = !clk_q;
                    if (st_q.pending) begin
                        st_d.half    = st_q.pend_cfg.half;
                        st_d.pending = 1'b0;
                    end
                end
            end else begin
                st_d.cnt = st_q.cnt + CNT_W_DEF'(1);
            end
        end else if (st_q.pending) begin
            st_d.cnt     = '0;
            clk_d        = 1'b0;
            st_d.half    = st_q.pend_cfg.half;
            st_d.enabled = st_q.pend_cfg.enable;
            st_d.pending = 1'b0;
        end
        // Acceptance only happens with no pending slot, so it never races an apply.
        if (cfg_we_i) begin
            st_d.pending  = 1'b1;
            st_d.pend_cfg = cfg_i;
        end
        tick_d = clk_d && !clk_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q   <= '{cnt: '0, half: CNT_W_DEF'(DEFAULT_HALF), enabled: 1'b1,
                        pending: 1'b0, pend_cfg: '0};
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign pending_o = st_q.pending;
    assign clk_o     = clk_q;
    assign tick_o    = tick_q;

endmodule

// File: rtl/clock_divider_bank.sv
// Multi-channel glitch-free programmable clock divider with valid/ready config port.
// `define CLOCK_DIV_SYNC_EN adds sync_req to phase-align all enabled channels.
module clock_divider_bank
    import clock_divider_pkg::*;
#(
    parameter  int NUM_CH       = 4,
    parameter  int CNT_W        = CNT_W_DEF,
    parameter  int DEFAULT_HALF = DEFAULT_HALF_DEF,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              input_clock,
    input  logic              input_reset_n,
`ifdef CLOCK_DIV_SYNC_EN
    input  logic              sync_req,
`endif
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_channel,
    input  logic [CNT_W-1:0]  cfg_half,
    input  logic              cfg_enable,
    output logic [NUM_CH-1:0] output_clock,
    output logic [NUM_CH-1:0] output_tick
);

    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] we;
    cfg_t              cfg;

    // Channel state is held at package width; CNT_W must not exceed CNT_W_DEF.
    assign cfg = '{half: CNT_W_DEF'(cfg_half), enable: cfg_enable};

    // Out-of-range channels match nothing: ready stays 1 and the request is dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_channel == CH_W'(i)) cfg_ready = !pend[i];
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign we[g] = cfg_valid && cfg_ready && (cfg_channel == CH_W'(g));

        clock_divider_channel #(
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .clk_i     (input_clock),
            .rst_ni    (input_reset_n),
`ifdef CLOCK_DIV_SYNC_EN
            .sync_i    (sync_req),
`endif
            .cfg_we_i  (we[g]),
            .cfg_i     (cfg),
            .pending_o (pend[g]),
            .clk_o     (output_clock[g]),
            .tick_o    (output_tick[g])
        );
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed bench for clock_divider_bank: NUM_CH=2, DEFAULT_HALF=3 (period 8).
module tb_clock_divider_bank;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 8;

    logic              input_clock;
    logic              input_reset_n;
`ifdef CLOCK_DIV_SYNC_EN
    logic              sync_req;
`endif
    logic              cfg_valid;
    logic              cfg_ready;
    logic [0:0]        cfg_channel;
    logic [CNT_W-1:0]  cfg_half;
    logic              cfg_enable;
    logic [NUM_CH-1:0] output_clock;
    logic [NUM_CH-1:0] output_tick;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] clk;
        logic [1:0] tick;
    } vec_t;
    vec_t vec [16];

    clock_divider_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_HALF(3)) dut (
        .input_clock   (input_clock),
        .input_reset_n (input_reset_n),
`ifdef CLOCK_DIV_SYNC_EN
        .sync_req      (sync_req),
`endif
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_channel   (cfg_channel),
        .cfg_half      (cfg_half),
        .cfg_enable    (cfg_enable),
        .output_clock  (output_clock),
        .output_tick   (output_tick)
    );

    initial input_clock = 1'b0;
    always #5 input_clock = ~input_clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic nx();
        @(negedge input_clock);
    endtask

    task automatic cfg(input int ch, input int half, input logic en);
        cfg_valid   = 1'b1;
        cfg_channel = 1'(ch);
        cfg_half    = CNT_W'(half);
        cfg_enable  = en;
    endtask

    task automatic idle();
        cfg_valid = 1'b0;
    endtask

    // Expects reset asserted on entry; releases it on a falling edge and walks 16 cycles.
    task automatic run_table();
        nx();
        chk("rst_clk", 32'(output_clock), 32'd0);
        chk("rst_tick", 32'(output_tick), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        input_reset_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            nx();
            chk($sformatf("tbl_clk[%0d]", k + 1), 32'(output_clock), 32'(vec[k].clk));
            chk($sformatf("tbl_tick[%0d]", k + 1), 32'(output_tick), 32'(vec[k].tick));
        end
    endtask

    initial begin
        // Edge k after release: rise at 4 and 12, fall at 8 and 16.
        vec[0]  = '{2'b00, 2'b00}; vec[1]  = '{2'b00, 2'b00};
        vec[2]  = '{2'b00, 2'b00}; vec[3]  = '{2'b11, 2'b11};
        vec[4]  = '{2'b11, 2'b00}; vec[5]  = '{2'b11, 2'b00};
        vec[6]  = '{2'b11, 2'b00}; vec[7]  = '{2'b00, 2'b00};
        vec[8]  = '{2'b00, 2'b00}; vec[9]  = '{2'b00, 2'b00};
        vec[10] = '{2'b00, 2'b00}; vec[11] = '{2'b11, 2'b11};
        vec[12] = '{2'b11, 2'b00}; vec[13] = '{2'b11, 2'b00};
        vec[14] = '{2'b11, 2'b00}; vec[15] = '{2'b00, 2'b00};

        input_reset_n = 1'b0;
        cfg_valid     = 1'b0;
        cfg_channel   = 1'b0;
        cfg_half      = '0;
        cfg_enable    = 1'b0;
`ifdef CLOCK_DIV_SYNC_EN
        sync_req      = 1'b0;
`endif
        nx();
        run_table();

        // ch1 -> half 0, applied at its next terminal; ch0 keeps period 8.
        cfg(1, 0, 1'b1); #1;
        chk("s2_ready_pre", 32'(cfg_ready), 32'd1);
        nx(); idle(); #1;
        chk("s2_ready_pend", 32'(cfg_ready), 32'd0);
        repeat (2) nx();
        chk("s2_ready_hold", 32'(cfg_ready), 32'd0);
        chk("s2_clk1_low", 32'(output_clock[1]), 32'd0);
        nx();
        chk("s2_clk_e20", 32'(output_clock), 32'd3);
        chk("s2_tick_e20", 32'(output_tick), 32'd3);
        chk("s2_ready_free", 32'(cfg_ready), 32'd1);
        nx();
        chk("s2_clk_e21", 32'(output_clock), 32'd1);
        chk("s2_tick_e21", 32'(output_tick), 32'd0);
        nx();
        chk("s2_clk_e22", 32'(output_clock), 32'd3);
        chk("s2_tick_e22", 32'(output_tick), 32'd2);
        nx();
        chk("s2_clk_e23", 32'(output_clock), 32'd1);
        nx();
        chk("s2_clk_e24", 32'(output_clock), 32'd2);
        chk("s2_tick_e24", 32'(output_tick), 32'd2);

        // Back-to-back ch0 writes stall; a ch1 write slips in meanwhile.
        cfg(0, 3, 1'b1); #1;
        chk("s3_ready_a", 32'(cfg_ready), 32'd1);
        nx();
        cfg(1, 0, 1'b1); #1;
        chk("s3_ready_ch1", 32'(cfg_ready), 32'd1);
        nx();
        idle(); #1;
        chk("s3_ch1_pending", 32'(cfg_ready), 32'd0);
        cfg(0, 3, 1'b1); #1;
        chk("s3_stall_e26", 32'(cfg_ready), 32'd0);
        nx();
        chk("s3_stall_e27", 32'(cfg_ready), 32'd0);
        nx();
        chk("s3_ready_e28", 32'(cfg_ready), 32'd1);
        chk("s3_clk0_e28", 32'(output_clock[0]), 32'd1);
        chk("s3_tick0_e28", 32'(output_tick[0]), 32'd1);
        nx();
        chk("s3_accept_b", 32'(cfg_ready), 32'd0);
        idle();
        repeat (3) nx();
        chk("s3_ready_e32", 32'(cfg_ready), 32'd1);
        chk("s3_clk0_e32", 32'(output_clock[0]), 32'd0);

        // Disable ch0 while low: one full high phase, then silent.
        cfg(0, 3, 1'b0);
        nx(); idle();
        repeat (3) nx();
        chk("s4_rise", 32'(output_clock[0]), 32'd1);
        chk("s4_rise_tick", 32'(output_tick[0]), 32'd1);
        repeat (3) nx();
        chk("s4_high_e39", 32'(output_clock[0]), 32'd1);
        nx();
        chk("s4_fall", 32'(output_clock[0]), 32'd0);
        chk("s4_ready", 32'(cfg_ready), 32'd1);
        for (int k = 0; k < 8; k++) begin
            nx();
            chk($sformatf("s4_off_clk[%0d]", k), 32'(output_clock[0]), 32'd0);
            chk($sformatf("s4_off_tick[%0d]", k), 32'(output_tick[0]), 32'd0);
        end
        // Re-enable with half 1: applied the cycle after acceptance, rise two later.
        cfg(0, 1, 1'b1);
        nx(); idle(); #1;
        chk("s4_re_pend", 32'(cfg_ready), 32'd0);
        nx();
        chk("s4_re_apply_clk", 32'(output_clock[0]), 32'd0);
        chk("s4_re_apply_rdy", 32'(cfg_ready), 32'd1);
        nx();
        chk("s4_re_e51", 32'(output_clock[0]), 32'd0);
        nx();
        chk("s4_re_rise", 32'(output_clock[0]), 32'd1);
        chk("s4_re_tick", 32'(output_tick[0]), 32'd1);
        nx();
        chk("s4_re_e53", 32'(output_clock[0]), 32'd1);
        chk("s4_re_e53_tick", 32'(output_tick[0]), 32'd0);
        nx();
        chk("s4_re_fall", 32'(output_clock[0]), 32'd0);

        // Reset in mid high phase with a disable pending on ch0.
        cfg(0, 3, 1'b0);
        nx(); idle(); #1;
        chk("s5_pend", 32'(cfg_ready), 32'd0);
        nx();
        chk("s5_high", 32'(output_clock[0]), 32'd1);
        chk("s5_pend_kept", 32'(cfg_ready), 32'd0);
        #1 input_reset_n = 1'b0;
        #1;
        chk("s5_async_clk", 32'(output_clock), 32'd0);
        chk("s5_async_tick", 32'(output_tick), 32'd0);
        chk("s5_async_ready", 32'(cfg_ready), 32'd1);
        run_table();

`ifdef CLOCK_DIV_SYNC_EN
        // Skew ch1 to half 1, queue half 3 on it, then align both with sync_req.
        cfg(1, 1, 1'b1);
        nx(); idle();
        repeat (3) nx();
        nx();
        cfg(1, 3, 1'b1);
        nx();
        idle();
        sync_req = 1'b1;
        nx();
        sync_req = 1'b0;
        chk("sync_clk", 32'(output_clock), 32'd0);
        chk("sync_tick", 32'(output_tick), 32'd0);
        repeat (3) nx();
        chk("sync_low_e26", 32'(output_clock), 32'd0);
        nx();
        chk("sync_rise", 32'(output_clock), 32'd3);
        chk("sync_rise_tick", 32'(output_tick), 32'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clock_divider_bank.md
Name: clock_divider_bank

Overview:
Multi-channel programmable clock divider. Each channel has its own runtime-programmable half-period, enable and tick output. All channels run from one fast board clock and produce slow, square-wave output clocks with 50% duty. Used for display refresh, LED blink and debounce timing. Configuration arrives through a valid/ready port, and new settings take effect only at a period boundary so the outputs never glitch.

Parameters:
NUM_CH, 4, number of independent divider channels (≥1)
CNT_W, 25, width of each channel's counter and half-period register
DEFAULT_HALF, 8333333, reset value of every channel's half-period terminal count (must fit CNT_W)

Ports:
input_clock  in  1  system clock; all logic rising-edge
input_reset_n  in  1  asynchronous active-low reset
cfg_valid  in  1  configuration request
cfg_ready  out  1  block can accept request for cfg_channel
cfg_channel  in  max(1,$clog2(NUM_CH))  target channel
cfg_half  in  CNT_W  new terminal count; half-period = cfg_half+1 cycles
cfg_enable  in  1  new enable state for target channel
output_clock  out  NUM_CH  divided clocks, registered
output_tick  out  NUM_CH  one-cycle pulse, asserted in the cycle output_clock[i] goes 0→1

Behaviour:
- Reset (async on input_reset_n low, held until release):
  - every cnt = 0, half = DEFAULT_HALF, enabled = 1
  - output_clock = 0, output_tick = 0
  - no pending config; cfg_ready = 1
- Channels therefore free-run from reset release.
- Per channel, enabled, each cycle:
  - if cnt == half: cnt <= 0, output_clock toggles, and pending config (if any) is applied.
  - otherwise cnt <= cnt+1.
  - Period = 2*(half+1) input cycles.
  - half = 0 gives divide-by-2.
  - half = all-ones is legal; no wrap occurs because cnt never exceeds half.
- output_tick[i] is high in the same cycle output_clock[i] is registered from 0 to 1. First rise after reset release occurs DEFAULT_HALF+1 cycles after the first active edge.
- Handshake:
  - a request is accepted when cfg_valid && cfg_ready.
  - cfg_ready = !pending[cfg_channel] (combinational on cfg_channel).
  - cfg_channel ≥ NUM_CH: accepted and dropped.
  - At most one pending config per channel; requests for other channels are independent.
- Applying pending config:
  - Channel enabled, new enable = 1: half updated at the next terminal count. The cycle after, counting uses the new half.
  - Channel enabled, new enable = 0: applied only at a terminal count where output_clock = 1. output goes 0, cnt held 0, enabled = 0. A terminal count with output 0 still toggles normally, so the final high phase completes.
  - Channel disabled: applied the cycle after acceptance. If enable = 1, counting starts with cnt = 0 and output 0, and the first rise comes new_half+1 cycles later. If enable = 0, only half is updated.
- Simultaneous events: a config accepted in the same cycle as that channel's terminal count is not applied at that terminal; it waits for the next qualifying boundary.
- Reset mid-period: outputs drop to 0 immediately (asynchronous) and pending configs are lost.

Optional Feature:
CLOCK_DIV_SYNC_EN
- Defined: adds input port sync_req (1 bit). A cycle with sync_req = 1 forces cnt = 0 and output_clock = 0 on every enabled channel at the next edge, and suppresses output_tick that cycle. Pending configs are kept, and their enable/half is applied at the same edge. This phase-aligns all channels.
- Undefined: port absent; no alignment logic.

Decomposition:
- Package clock_divider_pkg holds:
  - CNT_W_DEF and DEFAULT_HALF_DEF constants
  - typedef cfg_t (half, enable)
  - typedef per-channel state struct (cnt, half, enabled, pending, pend_cfg)
- Sub-module clock_divider_channel: one counter, toggle, pending register and tick logic.
- Top level: generate loop over NUM_CH channels, plus the cfg decode and ready mux.

Test Plan:
- NUM_CH=2, DEFAULT_HALF=3, release reset → output_clock[0] and [1] rise 4 cycles after release, period 8, duty 4/4; output_tick one cycle high at each rise only.
- Ch1 running half=3, write cfg_half=0, enable=1 → cfg_ready low for ch1 until its next terminal; afterwards output_clock[1] toggles every cycle; ch0 unaffected.
- Back-to-back writes to ch0 with valid held → second write stalls (ready=0) until first is applied at the boundary, then is accepted; ch1 writes accepted meanwhile.
- Disable ch0 while output low, half=3 → output rises, stays high 4 cycles, falls and stays 0 with no ticks; re-enable with half=1 → first rise 2 cycles after apply.
- Assert input_reset_n low mid-high-phase → output_clock=0 immediately (same time step, no clock edge needed), pending cleared, cfg_ready=1; on release the default timing resumes.
- With CLOCK_DIV_SYNC_EN, channels at different phases, pulse sync_req → next edge all outputs 0 and cnt 0; all subsequent rises are coincident for equal half values.
